cordic_pre_fold: RTL and testbench

//  Parametrised CORDIC front-end for the Sobel gradient-direction path. Folds a signed (x,y)

---
 rtl/cordic_pre_fold_pkg.sv | 11 +
 rtl/cordic_pipe_dly.sv | 28 ++
 rtl/cordic_pre_fold.sv | 140 ++++++++++++++
 tb/tb_cordic_pre_fold.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pre_fold_pkg.sv
// Shared constants for the CORDIC pre-fold front-end.
// Info bit positions and the supported latency range.
package cordic_pre_fold_pkg;
   localparam int INFO_XS  = 3;
   localparam int INFO_YS  = 2;
   localparam int INFO_SW  = 1;
   localparam int INFO_SAT = 0;
   localparam int INFO_W   = 4;
   localparam int LAT_MIN  = 2;
   localparam int LAT_MAX  = 4;
endpackage

// File: rtl/cordic_pipe_dly.sv
// Resettable N-stage register delay line of width W.
// N=0 collapses to a plain wire.
module cordic_pipe_dly #(
   parameter int W = 1,
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   generate
      if (N == 0) begin : g_wire
         assign o_q = i_d;
      end else begin : g_dly
         logic [W-1:0] r_q [N];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < N; i++) r_q[i] <= '0;
            end else begin
               r_q[0] <= i_d;
               for (int i = 1; i < N; i++) r_q[i] <= r_q[i-1];
            end
         end
         assign o_q = r_q[N-1];
      end
   endgenerate
endmodule

// File: rtl/cordic_pre_fold.sv
// Folds a signed (x,y) vector into the first octant/quadrant for the
// CORDIC rotator, clamping to headroom and counting clamps per frame.
module cordic_pre_fold
   import cordic_pre_fold_pkg::*;
#(
   parameter int DW          = 16,
   parameter int LAT         = 2,
   parameter int FOLD_OCTANT = 1,
   parameter int SAT_EN      = 1,
   parameter int CNT_W       = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din_vsync,
   input  logic             din_hsync,
   input  logic [DW-1:0]    din_x,
   input  logic [DW-1:0]    din_y,
   output logic             dout_vsync,
   output logic             dout_hsync,
   output logic [DW-1:0]    dout_x,
   output logic [DW-1:0]    dout_y,
   output logic [3:0]       dout_info,
   output logic [CNT_W-1:0] frame_sat_cnt
);
   localparam int DLY_W = 2*DW + INFO_W + 2;
   localparam logic [DW-1:0] LIM = {2'b00, {(DW-2){1'b1}}};

   generate
      if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
         $error("cordic_pre_fold: LAT must be within 2..4");
      end
   endgenerate

   logic [DW-1:0] w_xm, w_ym, w_xa, w_ya;
   logic          w_xf, w_yf;

   // Unsigned negate keeps the most negative input as 2^(DW-1).
   assign w_xm = din_x[DW-1] ? -din_x : din_x;
   assign w_ym = din_y[DW-1] ? -din_y : din_y;
   assign w_xf = w_xm[DW-1] | w_xm[DW-2];
   assign w_yf = w_ym[DW-1] | w_ym[DW-2];
   assign w_xa = (SAT_EN != 0 && w_xf) ? LIM : w_xm;
   assign w_ya = (SAT_EN != 0 && w_yf) ? LIM : w_ym;

   logic [DW-1:0] r_xa, r_ya;
   logic          r_xs, r_ys, r_sat, r_hs1, r_vs1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xa  <= '0;
         r_ya  <= '0;
         r_xs  <= 1'b0;
         r_ys  <= 1'b0;
         r_sat <= 1'b0;
         r_hs1 <= 1'b0;
         r_vs1 <= 1'b0;
      end else begin
         r_hs1 <= din_hsync;
         r_vs1 <= din_vsync;
         if (din_hsync) begin
            r_xa  <= w_xa;
            r_ya  <= w_ya;
            r_xs  <= din_x[DW-1];
            r_ys  <= din_y[DW-1];
            r_sat <= w_xf | w_yf;
         end
      end
   end

   logic                w_sw;
   logic [INFO_W-1:0]   w_info;

   assign w_sw = (FOLD_OCTANT != 0) && (r_xa < r_ya);

   always_comb begin
      w_info           = '0;
      w_info[INFO_XS]  = r_xs;
      w_info[INFO_YS]  = r_ys;
      w_info[INFO_SW]  = w_sw;
      w_info[INFO_SAT] = r_sat;
   end

   logic [DW-1:0]     r_x2, r_y2;
   logic [INFO_W-1:0] r_i2;
   logic              r_hs2, r_vs2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x2  <= '0;
         r_y2  <= '0;
         r_i2  <= '0;
         r_hs2 <= 1'b0;
         r_vs2 <= 1'b0;
      end else begin
         r_hs2 <= r_hs1;
         r_vs2 <= r_vs1;
         r_x2  <= r_hs1 ? (w_sw ? r_ya : r_xa) : '0;
         r_y2  <= r_hs1 ? (w_sw ? r_xa : r_ya) : '0;
         r_i2  <= r_hs1 ? w_info : '0;
      end
   end

   logic [DLY_W-1:0] w_q;

   cordic_pipe_dly #(
      .W (DLY_W),
      .N (LAT - 2)
   ) u_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   ({r_vs2, r_hs2, r_i2, r_x2, r_y2}),
      .o_q   (w_q)
   );

   assign {dout_vsync, dout_hsync, dout_info, dout_x, dout_y} = w_q;

   logic [CNT_W-1:0] r_run, w_inc, w_next;
   logic             r_vs_d, w_hit, w_fall;

   assign w_hit  = dout_hsync & dout_info[INFO_SAT];
   assign w_fall = r_vs_d & ~dout_vsync;
   assign w_inc  = (&r_run) ? r_run : r_run + CNT_W'(1);
   assign w_next = w_hit ? w_inc : r_run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run         <= '0;
         r_vs_d        <= 1'b0;
         frame_sat_cnt <= '0;
      end else begin
         r_vs_d <= dout_vsync;
         if (w_fall) begin
            frame_sat_cnt <= w_next;
            r_run         <= '0;
         end else begin
            r_run <= w_next;
         end
      end
   end
endmodule

// File: tb/tb_cordic_pre_fold.sv
// Scoreboard bench: four configurations driven in parallel, a monitor
// pops expected samples and frame counts as each DUT presents them.
module tb_cordic_pre_fold;
   localparam int DW = 16;
   localparam int CW = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic din_vsync = 1'b0;
   logic din_hsync = 1'b0;
   logic [DW-1:0] din_x = '0;
   logic [DW-1:0] din_y = '0;

   logic [3:0][DW-1:0] ox, oy;
   logic [3:0][3:0]    oi;
   logic [3:0]         ohs, ovs;
   logic [3:0][CW-1:0] ofs;

   always #5 clk = ~clk;

   // 0: default, 1: quadrant fold, 2: no saturation, 3: LAT=4
   cordic_pre_fold #(.DW(DW), .LAT(2), .FOLD_OCTANT(1), .SAT_EN(1), .CNT_W(CW)) u_def (
      .clk(clk), .rst_n(rst_n), .din_vsync(din_vsync), .din_hsync(din_hsync),
      .din_x(din_x), .din_y(din_y), .dout_vsync(ovs[0]), .dout_hsync(ohs[0]),
      .dout_x(ox[0]), .dout_y(oy[0]), .dout_info(oi[0]), .frame_sat_cnt(ofs[0]));
   cordic_pre_fold #(.DW(DW), .LAT(2), .FOLD_OCTANT(0), .SAT_EN(1), .CNT_W(CW)) u_quad (
      .clk(clk), .rst_n(rst_n), .din_vsync(din_vsync), .din_hsync(din_hsync),
      .din_x(din_x), .din_y(din_y), .dout_vsync(ovs[1]), .dout_hsync(ohs[1]),
      .dout_x(ox[1]), .dout_y(oy[1]), .dout_info(oi[1]), .frame_sat_cnt(ofs[1]));
   cordic_pre_fold #(.DW(DW), .LAT(2), .FOLD_OCTANT(1), .SAT_EN(0), .CNT_W(CW)) u_nosat (
      .clk(clk), .rst_n(rst_n), .din_vsync(din_vsync), .din_hsync(din_hsync),
      .din_x(din_x), .din_y(din_y), .dout_vsync(ovs[2]), .dout_hsync(ohs[2]),
      .dout_x(ox[2]), .dout_y(oy[2]), .dout_info(oi[2]), .frame_sat_cnt(ofs[2]));
   cordic_pre_fold #(.DW(DW), .LAT(4), .FOLD_OCTANT(1), .SAT_EN(1), .CNT_W(CW)) u_lat4 (
      .clk(clk), .rst_n(rst_n), .din_vsync(din_vsync), .din_hsync(din_hsync),
      .din_x(din_x), .din_y(din_y), .dout_vsync(ovs[3]), .dout_hsync(ohs[3]),
      .dout_x(ox[3]), .dout_y(oy[3]), .dout_info(oi[3]), .frame_sat_cnt(ofs[3]));

   typedef struct {
      int        due;
      logic [15:0] x, y;
      logic [3:0]  info;
   } exp_t;

   typedef struct {
      logic signed [15:0] x, y;
      logic [15:0] ex, ey; logic [3:0] ei;
      logic [15:0] qx, qy; logic [3:0] qi;
      logic [15:0] ux, uy; logic [3:0] ui;
   } vec_t;

   vec_t V[9];
   exp_t sbq[4][$];
   int   fq[4][$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   logic vs_hist[0:8191];
   logic [3:0] pv = '0;
   logic [3:0] pf = '0;

   function automatic int lat_of(int d);
      return (d == 3) ? 4 : 2;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      int   L;
      vs_hist[cyc % 8192] = din_vsync & rst_n;
      if (!rst_n) begin
         pv = '0;
         pf = '0;
      end else begin
         for (int d = 0; d < 4; d++) begin
            L = lat_of(d);
            if (cyc >= L)
               chk($sformatf("vsync_d%0d", d), ovs[d], vs_hist[(cyc - L) % 8192]);
            if (ohs[d]) begin
               if (sbq[d].size() == 0) begin
                  chk($sformatf("unexpected_out_d%0d", d), 1, 0);
               end else begin
                  e = sbq[d].pop_front();
                  chk($sformatf("latency_d%0d", d), cyc, e.due);
                  chk($sformatf("x_d%0d", d), ox[d], e.x);
                  chk($sformatf("y_d%0d", d), oy[d], e.y);
                  chk($sformatf("info_d%0d", d), oi[d], e.info);
               end
            end else begin
               chk($sformatf("zero_gate_d%0d", d), {oi[d], ox[d], oy[d]}, 0);
            end
            if (pf[d]) begin
               if (fq[d].size() == 0) chk($sformatf("frame_unexp_d%0d", d), 1, 0);
               else chk($sformatf("frame_cnt_d%0d", d), ofs[d], fq[d].pop_front());
            end
            pf[d] = pv[d] & ~ovs[d];
            pv[d] = ovs[d];
         end
      end
   end

   task automatic drive(logic vs, logic hs, logic [15:0] x, logic [15:0] y);
      @(posedge clk);
      #1;
      din_vsync = vs;
      din_hsync = hs;
      din_x     = x;
      din_y     = y;
   endtask

   task automatic send(int i, logic vs);
      exp_t e;
      drive(vs, 1'b1, V[i].x, V[i].y);
      for (int d = 0; d < 4; d++) begin
         e.due = cyc + lat_of(d);
         if (d == 1) begin
            e.x = V[i].qx; e.y = V[i].qy; e.info = V[i].qi;
         end else if (d == 2) begin
            e.x = V[i].ux; e.y = V[i].uy; e.info = V[i].ui;
         end else begin
            e.x = V[i].ex; e.y = V[i].ey; e.info = V[i].ei;
         end
         sbq[d].push_back(e);
      end
   endtask

   task automatic idle(int n, logic vs);
      repeat (n) drive(vs, 1'b0, 16'h1234, 16'hbeef);
   endtask

   task automatic end_frame(int n);
      for (int d = 0; d < 4; d++) fq[d].push_back(n);
   endtask

   task automatic rst_check();
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("rst_out_d%0d", d), {ox[d], oy[d], oi[d], ohs[d], ovs[d]}, 0);
         chk($sformatf("rst_frame_d%0d", d), ofs[d], 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      V[0] = '{-16'sd300, 16'sd100, 16'd300, 16'd100, 4'b1000,
               16'd300, 16'd100, 4'b1000, 16'd300, 16'd100, 4'b1000};
      V[1] = '{16'sd100, -16'sd300, 16'd300, 16'd100, 4'b0110,
               16'd100, 16'd300, 4'b0100, 16'd300, 16'd100, 4'b0110};
      V[2] = '{-16'sd50, -16'sd50, 16'd50, 16'd50, 4'b1100,
               16'd50, 16'd50, 4'b1100, 16'd50, 16'd50, 4'b1100};
      V[3] = '{-16'sd32768, 16'sd20000, 16'd16383, 16'd16383, 4'b1001,
               16'd16383, 16'd16383, 4'b1001, 16'd32768, 16'd20000, 4'b1001};
      V[4] = '{16'sd5, -16'sd20000, 16'd16383, 16'd5, 4'b0111,
               16'd5, 16'd16383, 4'b0101, 16'd20000, 16'd5, 4'b0111};
      V[5] = '{16'sd16383, 16'sd0, 16'd16383, 16'd0, 4'b0000,
               16'd16383, 16'd0, 4'b0000, 16'd16383, 16'd0, 4'b0000};
      V[6] = '{16'sd16384, -16'sd16384, 16'd16383, 16'd16383, 4'b0101,
               16'd16383, 16'd16383, 4'b0101, 16'd16384, 16'd16384, 4'b0101};
      V[7] = '{16'sd0, 16'sd1, 16'd1, 16'd0, 4'b0010,
               16'd0, 16'd1, 4'b0000, 16'd1, 16'd0, 4'b0010};
      V[8] = '{16'sd32767, -16'sd32767, 16'd16383, 16'd16383, 4'b0101,
               16'd16383, 16'd16383, 4'b0101, 16'd32767, 16'd32767, 4'b0101};

      repeat (3) @(posedge clk);
      #1;
      rst_check();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3, 1'b0);

      // frame A: three clamped samples (3, 4, 6)
      idle(1, 1'b1);
      send(0, 1'b1); send(1, 1'b1); send(2, 1'b1);
      idle(2, 1'b1);
      send(3, 1'b1);
      idle(1, 1'b1);
      send(4, 1'b1); send(6, 1'b1); send(5, 1'b1); send(7, 1'b1);
      idle(3, 1'b1);
      idle(1, 1'b0);
      end_frame(3);
      idle(8, 1'b0);

      // frame B: clean
      idle(1, 1'b1);
      send(0, 1'b1); send(5, 1'b1); send(7, 1'b1);
      idle(2, 1'b1);
      idle(1, 1'b0);
      end_frame(0);
      idle(8, 1'b0);

      // frame C: clamped sample arrives on the vsync falling edge
      idle(1, 1'b1);
      send(8, 1'b1);
      idle(1, 1'b1);
      send(3, 1'b0);
      end_frame(2);
      idle(8, 1'b0);

      // line data outside a frame
      send(1, 1'b0); send(2, 1'b0);
      idle(6, 1'b0);

      // reset in the middle of a line with clamped data in flight
      idle(1, 1'b1);
      send(3, 1'b1); send(4, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      din_hsync = 1'b0;
      din_vsync = 1'b0;
      for (int d = 0; d < 4; d++) begin
         sbq[d].delete();
         fq[d].delete();
      end
      #1;
      rst_check();
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2, 1'b0);

      // frame D: only the post-reset clamp counts
      idle(1, 1'b1);
      send(6, 1'b1); send(0, 1'b1);
      idle(2, 1'b1);
      idle(1, 1'b0);
      end_frame(1);
      idle(10, 1'b0);

      for (int d = 0; d < 4; d++) begin
         chk($sformatf("sb_drained_d%0d", d), sbq[d].size(), 0);
         chk($sformatf("frames_drained_d%0d", d), fq[d].size(), 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
